// File: rtl/data_bus_arb_pkg.sv
// Shared types and defaults for the data bus arbiter slice.
package data_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        TURN
    } arb_state_t;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 11;
    localparam int MAX_REQ = 8;

    function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (onehot[i]) begin
                idx = i[2:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/data_bus_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first requester at or after rr_ptr.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);
    import data_bus_arb_pkg::*;

    int   idx;
    logic found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && req[idx[IDX_W-1:0]]) begin
                winner = idx[IDX_W-1:0];
                found  = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/data_bus_arbiter.sv
// Round-robin owner arbitration for the shared data/address bus, with a hold
// limit per ownership and a dead turnaround cycle between owners.
module data_bus_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = data_bus_arb_pkg::DATA_W,
    parameter int ADDR_W   = data_bus_arb_pkg::ADDR_W,
    parameter int MAX_HOLD = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      bus_valid,
    output logic                      bus_wr,
    output logic [ADDR_W-1:0]         bus_addr,
    output logic [DATA_W-1:0]         bus_wdata,
    input  logic                      bus_ready,
    input  logic [DATA_W-1:0]         bus_rdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      preempt
);
    import data_bus_arb_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HC_W  = $clog2(MAX_HOLD + 1);

    arb_state_t       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] next_ptr;
    logic             any_req;
    logic [HC_W-1:0]  hold_cnt;
    logic             owned;
    logic             beat_done;
    logic             last_hit;
    logic             hold_hit;
    logic             drop_hit;
    logic             release_now;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    assign owner    = IDX_W'(onehot_to_idx(MAX_REQ'(gnt)));
    assign owned    = (state == OWN);
    assign next_ptr = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    // Everything on the bus is gated by the registered grant so a non-owner never drives it.
    always_comb begin
        bus_valid = 1'b0;
        bus_wr    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        if (owned) begin
            bus_valid = req_valid[owner];
            bus_wr    = req_wr[owner];
            bus_addr  = req_addr[owner*ADDR_W +: ADDR_W];
            bus_wdata = req_wdata[owner*DATA_W +: DATA_W];
        end
    end

    assign beat_done   = bus_valid && bus_ready;
    assign rsp_valid   = beat_done ? gnt : '0;
    assign rsp_rdata   = (beat_done && !bus_wr) ? bus_rdata : '0;

    assign last_hit    = beat_done && req_last[owner];
    assign hold_hit    = beat_done && (hold_cnt == HC_W'(MAX_HOLD - 1));
    assign drop_hit    = !req[owner] && !beat_done;
    assign release_now = last_hit || hold_hit || drop_hit;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            gnt      <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            preempt  <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt      <= NUM_REQ'(1) << winner;
                        hold_cnt <= '0;
                        state    <= OWN;
                    end
                end
                OWN: begin
                    if (beat_done && (hold_cnt != HC_W'(MAX_HOLD))) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                    if (release_now) begin
                        gnt     <= '0;
                        rr_ptr  <= next_ptr;
                        preempt <= hold_hit && !req_last[owner];
                        state   <= TURN;
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: bursts, fairness, hold-limit preemption,
// stalled reads, request drop and mid-burst reset, all with hand-computed expectations.
module tb_data_bus_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 11;
    localparam int MAX_HOLD = 4;

    logic                      clk;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_wr;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic                      bus_valid;
    logic                      bus_wr;
    logic [ADDR_W-1:0]         bus_addr;
    logic [DATA_W-1:0]         bus_wdata;
    logic                      bus_ready;
    logic [DATA_W-1:0]         bus_rdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      preempt;

    int vectors     = 0;
    int miscompares = 0;

    data_bus_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .bus_valid (bus_valid),
        .bus_wr    (bus_wr),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .preempt   (preempt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic rq, input logic vld, input logic lst,
                                 input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        req[idx]                       = rq;
        req_valid[idx]                 = vld;
        req_last[idx]                  = lst;
        req_wr[idx]                    = wr;
        req_addr[idx*ADDR_W +: ADDR_W] = addr;
        req_wdata[idx*DATA_W +: DATA_W] = wdata;
    endtask

    task automatic clear_inputs();
        req       = '0;
        req_valid = '0;
        req_last  = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    // Inputs change on the falling edge; checks run 1 time unit later, well before the rising edge.
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset_n   = 1'b0;
        bus_ready = 1'b0;
        bus_rdata = '0;
        clear_inputs();
        tick();
        tick();
        #1;
        checkOutput("rst_gnt", 32'(gnt), 32'h0);
        checkOutput("rst_bus_valid", 32'(bus_valid), 32'h0);
        checkOutput("rst_preempt", 32'(preempt), 32'h0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("rst_bus_addr", 32'(bus_addr), 32'h0);

        $display("[TB] single burst from requester 0");
        tick();
        reset_n   = 1'b1;
        bus_ready = 1'b1;
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b1, 11'h010, 16'hA1A1);
        #1;
        checkOutput("t1_gnt_before", 32'(gnt), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            applyStimulus(0, 1'b1, 1'b1, (k == 2), 1'b1, 11'(11'h010 + k), 16'(16'hA1A1 + k));
            #1;
            checkOutput("t1_gnt", 32'(gnt), 32'h1);
            checkOutput("t1_bus_addr", 32'(bus_addr), 32'(11'h010 + k));
            checkOutput("t1_bus_wdata", 32'(bus_wdata), 32'(16'hA1A1 + k));
            checkOutput("t1_bus_wr", 32'(bus_wr), 32'h1);
            checkOutput("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        end
        tick();
        clear_inputs();
        #1;
        checkOutput("t1_turn_gnt", 32'(gnt), 32'h0);
        checkOutput("t1_turn_valid", 32'(bus_valid), 32'h0);
        checkOutput("t1_turn_addr", 32'(bus_addr), 32'h0);
        tick();
        #1;
        checkOutput("t1_idle_gnt", 32'(gnt), 32'h0);
        checkOutput("t1_idle_preempt", 32'(preempt), 32'h0);

        $display("[TB] simultaneous requests 1 and 2 at reset exit");
        tick();
        reset_n = 1'b0;
        tick();
        #1;
        checkOutput("t2_rst_gnt", 32'(gnt), 32'h0);
        reset_n = 1'b1;
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 1'b1, 11'h100, 16'h1111);
        applyStimulus(2, 1'b1, 1'b1, 1'b1, 1'b1, 11'h200, 16'h2222);
        tick();
        #1;
        checkOutput("t2_first_gnt", 32'(gnt), 32'h2);
        checkOutput("t2_first_addr", 32'(bus_addr), 32'h100);
        checkOutput("t2_first_rsp", 32'(rsp_valid), 32'h2);
        tick();
        #1;
        checkOutput("t2_turn_gnt", 32'(gnt), 32'h0);
        tick();
        #1;
        checkOutput("t2_idle_gnt", 32'(gnt), 32'h0);
        tick();
        #1;
        checkOutput("t2_second_gnt", 32'(gnt), 32'h4);
        checkOutput("t2_second_addr", 32'(bus_addr), 32'h200);
        checkOutput("t2_second_wdata", 32'(bus_wdata), 32'h2222);
        tick();
        clear_inputs();
        #1;
        checkOutput("t2_end_gnt", 32'(gnt), 32'h0);
        tick();

        $display("[TB] hold limit on a 6-beat burst from requester 3");
        tick();
        applyStimulus(3, 1'b1, 1'b1, 1'b0, 1'b1, 11'h301, 16'h3001);
        #1;
        checkOutput("t3_gnt_before", 32'(gnt), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            applyStimulus(3, 1'b1, 1'b1, 1'b0, 1'b1, 11'(11'h300 + k), 16'(16'h3000 + k));
            #1;
            checkOutput("t3_gnt", 32'(gnt), 32'h8);
            checkOutput("t3_bus_addr", 32'(bus_addr), 32'(11'h300 + k));
            checkOutput("t3_rsp_valid", 32'(rsp_valid), 32'h8);
            checkOutput("t3_no_preempt", 32'(preempt), 32'h0);
        end
        tick();
        applyStimulus(3, 1'b1, 1'b1, 1'b0, 1'b1, 11'h305, 16'h3005);
        #1;
        checkOutput("t3_preempt", 32'(preempt), 32'h1);
        checkOutput("t3_turn_gnt", 32'(gnt), 32'h0);
        checkOutput("t3_turn_valid", 32'(bus_valid), 32'h0);
        tick();
        #1;
        checkOutput("t3_preempt_pulse", 32'(preempt), 32'h0);
        checkOutput("t3_idle_gnt", 32'(gnt), 32'h0);
        tick();
        #1;
        checkOutput("t3_regrant", 32'(gnt), 32'h8);
        checkOutput("t3_beat5_addr", 32'(bus_addr), 32'h305);
        checkOutput("t3_beat5_rsp", 32'(rsp_valid), 32'h8);
        tick();
        applyStimulus(3, 1'b1, 1'b1, 1'b1, 1'b1, 11'h306, 16'h3006);
        #1;
        checkOutput("t3_beat6_addr", 32'(bus_addr), 32'h306);
        tick();
        clear_inputs();
        #1;
        checkOutput("t3_end_gnt", 32'(gnt), 32'h0);
        checkOutput("t3_end_preempt", 32'(preempt), 32'h0);
        tick();

        $display("[TB] stalled read from requester 0");
        tick();
        bus_ready = 1'b0;
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b0, 11'h055, 16'h0000);
        #1;
        for (int k = 0; k < 5; k++) begin
            tick();
            #1;
            checkOutput("t4_stall_addr", 32'(bus_addr), 32'h055);
            checkOutput("t4_stall_valid", 32'(bus_valid), 32'h1);
            checkOutput("t4_stall_wr", 32'(bus_wr), 32'h0);
            checkOutput("t4_stall_rsp", 32'(rsp_valid), 32'h0);
        end
        tick();
        bus_ready = 1'b1;
        bus_rdata = 16'h5A5A;
        #1;
        checkOutput("t4_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("t4_rsp_rdata", 32'(rsp_rdata), 32'h5A5A);
        tick();
        clear_inputs();
        bus_ready = 1'b0;
        bus_rdata = '0;
        #1;
        checkOutput("t4_end_gnt", 32'(gnt), 32'h0);
        tick();

        $display("[TB] owner drops request with no beat pending");
        tick();
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 1'b0, 11'h0, 16'h0);
        tick();
        #1;
        checkOutput("t5_gnt", 32'(gnt), 32'h4);
        checkOutput("t5_bus_valid", 32'(bus_valid), 32'h0);
        tick();
        applyStimulus(2, 1'b0, 1'b0, 1'b0, 1'b0, 11'h0, 16'h0);
        #1;
        checkOutput("t5_gnt_held", 32'(gnt), 32'h4);
        tick();
        #1;
        checkOutput("t5_turn_gnt", 32'(gnt), 32'h0);
        checkOutput("t5_preempt", 32'(preempt), 32'h0);
        tick();
        #1;
        checkOutput("t5_idle_preempt", 32'(preempt), 32'h0);

        $display("[TB] reset during a burst from requester 3");
        tick();
        bus_ready = 1'b1;
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b1, 11'h0A0, 16'hA000);
        applyStimulus(3, 1'b1, 1'b1, 1'b0, 1'b1, 11'h3B0, 16'hB000);
        tick();
        #1;
        checkOutput("t6_gnt", 32'(gnt), 32'h8);
        checkOutput("t6_beat1_addr", 32'(bus_addr), 32'h3B0);
        tick();
        applyStimulus(3, 1'b1, 1'b1, 1'b0, 1'b1, 11'h3B1, 16'hB001);
        reset_n = 1'b0;
        #1;
        checkOutput("t6_beat2_valid", 32'(bus_valid), 32'h1);
        tick();
        #1;
        checkOutput("t6_rst_gnt", 32'(gnt), 32'h0);
        checkOutput("t6_rst_valid", 32'(bus_valid), 32'h0);
        checkOutput("t6_rst_rsp", 32'(rsp_valid), 32'h0);
        reset_n = 1'b1;
        tick();
        #1;
        checkOutput("t6_post_rst_gnt", 32'(gnt), 32'h1);
        checkOutput("t6_post_rst_addr", 32'(bus_addr), 32'h0A0);
        tick();
        clear_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_bus_arbiter.md
# data_bus_arbiter

Round-robin arbiter and sequencer for the shared 16-bit FPGA data/address bus used by the test generator, SDRAM controller, on-chip memory and MAC core. It replaces direct multi-driver hookup of that bus. Requesters gain exclusive ownership for a burst. Ownership is bounded by a hold limit, and a one-cycle turnaround with no owner is inserted between owners so tri-state drivers never overlap.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 16, bus data width
- ADDR_W, 11, bus address width
- MAX_HOLD, 16, max beats per ownership before forced release (≥1)
- clk  in  1  system clock (clk_internal domain)
- reset_n  in  1  synchronous, active-low reset
- req  in  NUM_REQ  per-requester ownership request
- req_valid  in  NUM_REQ  per-requester beat valid
- req_last  in  NUM_REQ  marks final beat of the burst
- req_wr  in  NUM_REQ  1 = write beat, 0 = read beat
- req_addr  in  NUM_REQ×ADDR_W  per-requester beat address
- req_wdata  in  NUM_REQ×DATA_W  per-requester write data
- gnt  out  NUM_REQ  one-hot ownership grant (registered)
- bus_valid, bus_wr  out  1  beat strobe and direction toward the target
- bus_addr  out  ADDR_W  muxed address
- bus_wdata  out  DATA_W  muxed write data
- bus_ready  in  1  target accepts the current beat
- bus_rdata  in  DATA_W  target read data, valid with bus_ready on read beats
- rsp_valid  out  NUM_REQ  one-hot beat-complete to the owner
- rsp_rdata  out  DATA_W  broadcast read data
- preempt  out  1  one-cycle pulse on forced release

## Operation
- States: IDLE, OWN, TURN. All state is held in registers.
- IDLE: when any req bit is high, the picker chooses the first requester at or after rr_ptr, wrapping. The next cycle, gnt = one-hot(winner), hold_cnt = 0, and the state becomes OWN.
- OWN: outputs are muxed from the owner. bus_valid = req_valid[owner]. A beat completes when bus_valid && bus_ready.
  - On each completed beat: rsp_valid[owner]=1 and hold_cnt increments.
  - Release triggers: (a) a completed beat with req_last, (b) a completed beat with hold_cnt == MAX_HOLD-1, or (c) req[owner]=0 while no beat completes that cycle.
  - On release: the next state is TURN, gnt=0, and rr_ptr = owner+1 mod NUM_REQ.
  - preempt fires only for trigger (b) without req_last.
- TURN: one cycle with gnt=0 and bus_valid=0, then IDLE. Arbitration happens in IDLE, so a requester that was preempted and still holds req competes fairly.
- With no owner, bus_addr, bus_wdata and bus_wr are driven to 0.
- Requests that arrive during OWN or TURN wait. There is no priority inversion and no starvation: the worst-case wait is (NUM_REQ-1)×(MAX_HOLD+2) cycles plus bus stall.
- Reset (reset_n=0 at a clock edge) from any state:
  - state=IDLE, gnt=0, rr_ptr=0, hold_cnt=0, preempt=0.
  - All bus outputs and rsp_valid are 0.
  - An in-flight beat is abandoned; the target must tolerate a dropped bus_valid.

## Timing
- Request-to-grant latency: 1 cycle from IDLE. Back-to-back owners are separated by exactly 2 idle bus cycles (TURN + IDLE).
- bus_valid, bus_addr, bus_wdata, bus_wr: combinational from owner inputs gated by registered gnt (0 cycles).
- rsp_valid and rsp_rdata: combinational with bus_ready (same cycle as beat acceptance).
- hold_cnt is $clog2(MAX_HOLD+1) bits and saturates; it is never compared past MAX_HOLD-1.
- The owner must hold req_addr, req_wdata and req_wr stable while req_valid is high and bus_ready is low.
- A beat that completes in the same cycle req drops counts as completed and is reported on rsp_valid; the release then follows trigger (a)/(b) or takes effect the next cycle.

## Structure
- Package data_bus_arb_pkg holds:
  - the state enum (IDLE, OWN, TURN)
  - default widths DATA_W and ADDR_W
  - a function for one-hot to index
- One sub-module, rr_picker: a combinational round-robin priority encoder with inputs req and rr_ptr, outputs winner index and any_req. It is also reusable by the control unit.
- The top of the block holds the FSM, hold counter, pointer and output muxes.

## Test plan
- Single burst: requester 0 sends 3 writes (addr 0x010..0x012, data 0xA1A1..) with bus_ready=1. Required: gnt=0001 one cycle after req, 3 rsp_valid pulses, release, then 2 idle cycles.
- Simultaneous request: req=0110 at reset exit. Required: grant order 1 then 2, with rr_ptr=2 after the first burst.
- Timeout: MAX_HOLD=4, requester 3 sends a 6-beat burst. Required: preempt pulses after beat 4; requester 3 regains the bus after TURN/IDLE and finishes beats 5–6.
- Stall and read: bus_ready low for 5 cycles on a read. Required: bus_addr stable, no rsp_valid until ready, then rsp_rdata=0x5A5A.
- Request drop: the owner deasserts req with no beat pending. Required: TURN next cycle and preempt stays 0.
- Mid-burst reset: reset_n low during beat 2. Required: the next cycle shows gnt=0, bus_valid=0 and IDLE, and the first grant after reset goes to the lowest active index.
